// File: rtl/req_serializer_4.sv
// Captures rising edges on four request lines and serializes them as one-hot grants over a valid/ready handshake.
// Latency: rise to pending is 1 edge, pending to out_valid is 1 more edge; stalls hold the grant; one event per cycle when ready.
module req_serializer_4 #(
    parameter bit RR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] pending,
    output logic       drop
);
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] req_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] out_q, out_d;
    logic [1:0] ptr_q, ptr_d;
    logic       drop_q, drop_d;
    logic [3:0] rise, fired, cand;
    logic [1:0] fired_idx, sel_start;
    logic       fire;

    // First set bit of 'set' scanning upward from 'start', wrapping 3->0.
    function automatic logic [3:0] pick(input logic [3:0] set, input logic [1:0] start);
        logic [3:0] g;
        logic [1:0] idx;
        g = '0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (g == 4'b0000 && set[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

    always_comb begin
        rise      = req & ~req_q;
        fire      = (state_q == OFFER) && out_ready;
        fired     = fire ? out_q : 4'b0000;
        fired_idx = {out_q[3] | out_q[2], out_q[3] | out_q[1]};
        pending_d = (pending_q & ~fired) | rise;
        drop_d    = |(rise & pending_q & ~fired);
        ptr_d     = fire ? fired_idx + 2'd1 : ptr_q;
        // Same-cycle rises are deliberately excluded from the candidate set.
        cand      = pending_q & ~fired;
        sel_start = RR ? ptr_d : 2'd0;
        state_d   = state_q;
        out_d     = out_q;
        case (state_q)
            IDLE: begin
                if (pending_q != 4'b0000) begin
                    out_d   = pick(pending_q, sel_start);
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (fire) begin
                    if (cand != 4'b0000) begin
                        out_d = pick(cand, sel_start);
                    end else begin
                        out_d   = 4'b0000;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                out_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // Edge history keeps tracking through reset so held levels are not events.
        req_q <= req;
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            out_q     <= 4'b0000;
            ptr_q     <= 2'd0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            ptr_q     <= ptr_d;
            drop_q    <= drop_d;
        end
    end

    assign out       = out_q;
    assign out_valid = (state_q == OFFER);
    assign pending   = pending_q;
    assign drop      = drop_q;
endmodule

// File: tb/tb_req_serializer_4.sv
// Bench for req_serializer_4: fixed-priority and round-robin instances driven in parallel, checked by table, directed sequences and a random run against an event-level model.
module tb_req_serializer_4;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [3:0] out_fp, out_rr, pend_fp, pend_rr;
    logic       vld_fp, vld_rr, drop_fp, drop_rr;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    req_serializer_4 #(.RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .out(out_fp), .out_valid(vld_fp),
        .out_ready(out_ready), .pending(pend_fp), .drop(drop_fp)
    );
    req_serializer_4 #(.RR(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .out(out_rr), .out_valid(vld_rr),
        .out_ready(out_ready), .pending(pend_rr), .drop(drop_rr)
    );

    // Model: index 0 = fixed priority, 1 = round robin. m_off is the offered bit index, -1 when nothing offered.
    logic [3:0] m_reqq;
    logic [3:0] m_pend [2];
    int         m_off  [2];
    int         m_ptr  [2];
    logic       m_drop [2];

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] e_out;
        logic       e_vld;
        logic [3:0] e_pend;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input int m, input logic [3:0] s, input int start);
        int idx;
        for (int i = 0; i < 4; i++) begin
            idx = (m == 1) ? (start + i) % 4 : i;
            if (s[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rdy, input logic rs);
        logic [3:0] rise, old, cands;
        int fired;
        if (rs) begin
            for (int m = 0; m < 2; m++) begin
                m_pend[m] = 4'b0000; m_off[m] = -1; m_ptr[m] = 0; m_drop[m] = 1'b0;
            end
            m_reqq = r;
            return;
        end
        rise   = r & ~m_reqq;
        m_reqq = r;
        for (int m = 0; m < 2; m++) begin
            old   = m_pend[m];
            fired = (m_off[m] >= 0 && rdy) ? m_off[m] : -1;
            m_drop[m] = 1'b0;
            for (int b = 0; b < 4; b++)
                if (rise[b] && old[b] && b != fired) m_drop[m] = 1'b1;
            cands = old;
            if (fired >= 0) begin
                cands[fired] = 1'b0;
                m_ptr[m] = (fired + 1) % 4;
            end
            if (m_off[m] < 0) begin
                if (old != 4'b0000) m_off[m] = pick(m, old, m_ptr[m]);
            end else if (fired >= 0) begin
                m_off[m] = pick(m, cands, m_ptr[m]);
            end
            m_pend[m] = cands | rise;
        end
    endtask

    task automatic cmp_model();
        logic [3:0] e [2];
        for (int m = 0; m < 2; m++) begin
            e[m] = 4'b0000;
            if (m_off[m] >= 0) e[m][m_off[m]] = 1'b1;
        end
        chk("fp_out",  out_fp,  e[0]);
        chk("fp_vld",  {3'b000, vld_fp},  {3'b000, m_off[0] >= 0});
        chk("fp_pend", pend_fp, m_pend[0]);
        chk("fp_drop", {3'b000, drop_fp}, {3'b000, m_drop[0]});
        chk("rr_out",  out_rr,  e[1]);
        chk("rr_vld",  {3'b000, vld_rr},  {3'b000, m_off[1] >= 0});
        chk("rr_pend", pend_rr, m_pend[1]);
        chk("rr_drop", {3'b000, drop_rr}, {3'b000, m_drop[1]});
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare at the next falling edge.
    task automatic cycle(input logic [3:0] r, input logic rdy, input logic rs);
        req = r; out_ready = rdy; rst = rs;
        @(posedge clk);
        model_step(r, rdy, rs);
        @(negedge clk);
        cmp_model();
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        m_reqq = 4'b0000;
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 4'b0000; m_off[m] = -1; m_ptr[m] = 0; m_drop[m] = 1'b0;
        end
        tbl[0]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1111};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0001, 1'b1, 4'b1111};
        tbl[2]  = '{4'b0000, 1'b1, 4'b0010, 1'b1, 4'b1110};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0100, 1'b1, 4'b1100};
        tbl[4]  = '{4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1111};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0001, 1'b1, 4'b1111};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0010, 1'b1, 4'b1110};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0100, 1'b1, 4'b1100};
        tbl[10] = '{4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[12] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 4'b0100};
        tbl[13] = '{4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};

        @(negedge clk);
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b1);
        chk("reset_vld", {3'b000, vld_rr}, 4'b0000);
        chk("reset_out", out_rr, 4'b0000);

        // Two round-robin rounds from reset, then a single pulse.
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].req, tbl[i].rdy, 1'b0);
            chk($sformatf("tbl%0d_rr_out", i), out_rr, tbl[i].e_out);
            chk($sformatf("tbl%0d_rr_vld", i), {3'b000, vld_rr}, {3'b000, tbl[i].e_vld});
            chk($sformatf("tbl%0d_rr_pend", i), pend_rr, tbl[i].e_pend);
            chk($sformatf("tbl%0d_fp_out", i), out_fp, tbl[i].e_out);
            chk($sformatf("tbl%0d_fp_pend", i), pend_fp, tbl[i].e_pend);
        end

        // Fixed priority drains 1011 lowest first.
        cycle(4'b1011, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0); chk("fp1011_a", out_fp, 4'b0001);
        cycle(4'b0000, 1'b1, 1'b0); chk("fp1011_b", out_fp, 4'b0010);
        cycle(4'b0000, 1'b1, 1'b0); chk("fp1011_c", out_fp, 4'b1000);
        cycle(4'b0000, 1'b1, 1'b0); chk("fp1011_end", {3'b000, vld_fp}, 4'b0000);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 1'b0);

        // Stalled grant stays put while a new event joins the pending set.
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b0); chk("stall_offer", out_fp, 4'b0010);
        cycle(4'b1010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1010, 1'b0, 1'b0);
            chk("stall_out_fp", out_fp, 4'b0010);
            chk("stall_out_rr", out_rr, 4'b0010);
            chk("stall_pend", pend_rr, 4'b1010);
        end
        cycle(4'b0000, 1'b1, 1'b0); chk("stall_next_fp", out_fp, 4'b1000); chk("stall_next_rr", out_rr, 4'b1000);
        cycle(4'b0000, 1'b1, 1'b0); chk("stall_done", {3'b000, vld_rr}, 4'b0000);

        // Re-rise on a stalled pending bit merges and pulses drop.
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0); chk("drop_offer", out_rr, 4'b0010);
        cycle(4'b0010, 1'b0, 1'b0); chk("drop_pulse", {3'b000, drop_rr}, 4'b0001); chk("drop_pend", pend_rr, 4'b0010);
        cycle(4'b0010, 1'b0, 1'b0); chk("drop_clear", {3'b000, drop_rr}, 4'b0000);
        cycle(4'b0000, 1'b1, 1'b0); chk("drop_one_grant", {3'b000, vld_rr}, 4'b0000);

        // Levels held through reset are not events; reset kills an offer.
        cycle(4'b0001, 1'b0, 1'b1);
        cycle(4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0001, 1'b1, 1'b0);
            chk("held_vld", {3'b000, vld_rr}, 4'b0000);
            chk("held_pend", pend_rr, 4'b0000);
        end
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0100, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0); chk("rst_offer", {3'b000, vld_rr}, 4'b0001);
        cycle(4'b0000, 1'b0, 1'b1); chk("rst_kill_vld", {3'b000, vld_rr}, 4'b0000); chk("rst_kill_pend", pend_rr, 4'b0000);

        for (int i = 0; i < 3000; i++)
            cycle(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/req_serializer_4.md
REQ_SERIALIZER_4 -- requirements
Module: req_serializer_4

Interface
REQ-001 Parameter RR, default 1: arbitration mode; 1 = round-robin, 0 = fixed priority with bit 0 highest.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  4  level request lines; each 0->1 transition is one event.
REQ-005 out  output  4  one-hot grant feeding the downstream 4-to-2 encoder; 4'b0000 when out_valid=0.
REQ-006 out_valid  output  1  out holds a valid one-hot event.
REQ-007 out_ready  input  1  downstream accepts out this cycle.
REQ-008 pending  output  4  registered set of captured, not-yet-accepted events.
REQ-009 drop  output  1  one-cycle pulse: an event was lost.

Function
REQ-010 Edge detect: req_q registers req each cycle; rise = req & ~req_q.
REQ-011 Handshake fires in a cycle with out_valid=1 and out_ready=1; fired = out in that cycle, else 4'b0000.
REQ-012 pending next = (pending & ~fired) | rise; a rise on a bit fired in the same cycle leaves that bit set as a new event.
REQ-013 drop=1 in the cycle after a rise on a bit that is pending and not fired that cycle; the event merges, is not counted twice.
REQ-014 out is never multi-hot; out and out_valid come straight from flops.
REQ-015 FSM, two states: IDLE (out_valid=0) and OFFER (out_valid=1).
REQ-016 IDLE: if pending != 0, load out with the selected bit and go to OFFER; else stay IDLE.
REQ-017 OFFER, out_ready=0: out held stable and pending bit kept set; no change of grant while stalled.
REQ-018 OFFER, handshake: candidates = pending & ~fired; if nonzero, load next selected bit and stay OFFER (back-to-back, one event per cycle); else go IDLE.
REQ-019 Same-cycle rises are not candidates; they become eligible next cycle.
REQ-020 RR=0: select lowest-index candidate.
REQ-021 RR=1: select first candidate scanning from ptr upward, wrapping 3->0; ptr resets to 0 and becomes (fired index + 1) mod 4 on each handshake.
REQ-022 Latency: req high first sampled at edge n -> pending bit set after edge n -> out_valid high after edge n+1 when IDLE.
REQ-023 out_ready while out_valid=0 has no effect.

Reset
REQ-024 While rst=1: pending=0, out=0, out_valid=0, drop=0, ptr=0, FSM=IDLE.
REQ-025 While rst=1, req_q loads req, so levels held through reset produce no event after release.
REQ-026 Reset mid-OFFER discards the offered and all pending events; out_valid is 0 after the reset edge.
REQ-027 First possible out_valid is two edges after the first rise following reset release.

Verification
REQ-028 req=4'b0100 pulse, out_ready=1 -> out_valid after 2 edges with out=4'b0100 for one cycle, then pending=0, out=0.
REQ-029 RR=0, req=4'b1011 in one cycle, out_ready=1 -> outs 0001, 0010, 1000 on consecutive cycles, then out_valid=0.
REQ-030 RR=1, req=4'b1111 repeated after each drain, out_ready=1 -> grants cycle 0001,0010,0100,1000, next round again from 0001 (ptr wraps to 0).
REQ-031 out_ready=0 for 5 cycles with out=0010 offered, new rise on bit 3 -> out stays 0010; pending=1010; after out_ready=1 grants 0010 then 1000.
REQ-032 Bit 1 pending and stalled, req[1] falls and rises again -> drop=1 for one cycle; only one 0010 grant delivered.
REQ-033 Hold req=4'b0001 through rst, release rst -> no out_valid; assert rst during OFFER -> out_valid=0 and pending=0 after one edge.
